// File: rtl/mmio_router_pkg.sv
// rtl/mmio_router_pkg.sv - shared constants, slot indices and FSM states for the MMIO router
package mmio_router_pkg;

    localparam logic [30:0] UART_BASE_DEF = 31'h6000_0000;
    localparam logic [30:0] BRAM_BASE_DEF = 31'h6001_0000;
    localparam logic [30:0] SPI_BASE_DEF  = 31'h6002_0000;

    localparam logic [30:0] UART_SIZE = 31'h0000_2000;
    localparam logic [30:0] BRAM_SIZE = 31'h0001_0000;
    localparam logic [30:0] SPI_SIZE  = 31'h0000_1000;

    localparam int          NSLOT     = 3;
    localparam logic [1:0]  SLOT_UART = 2'd0;
    localparam logic [1:0]  SLOT_BRAM = 2'd1;
    localparam logic [1:0]  SLOT_SPI  = 2'd2;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;

endpackage

// File: rtl/mmio_addr_decode.sv
// rtl/mmio_addr_decode.sv - maps a start address onto one of the three peripheral windows
module mmio_addr_decode
    import mmio_router_pkg::*;
#(
    parameter logic [30:0] UART_BASE = UART_BASE_DEF,
    parameter logic [30:0] BRAM_BASE = BRAM_BASE_DEF,
    parameter logic [30:0] SPI_BASE  = SPI_BASE_DEF
) (
    input  logic [30:0] addr_i,
    output logic [1:0]  slot_o,
    output logic        hit_o
);

    // Offset compare: addresses below a base wrap to a huge offset and miss.
    always_comb begin
        slot_o = SLOT_UART;
        hit_o  = 1'b0;
        if ((addr_i - UART_BASE) < UART_SIZE) begin
            slot_o = SLOT_UART;
            hit_o  = 1'b1;
        end else if ((addr_i - BRAM_BASE) < BRAM_SIZE) begin
            slot_o = SLOT_BRAM;
            hit_o  = 1'b1;
        end else if ((addr_i - SPI_BASE) < SPI_SIZE) begin
            slot_o = SLOT_SPI;
            hit_o  = 1'b1;
        end
    end

endmodule

// File: rtl/mmio_router.sv
// rtl/mmio_router.sv - one-to-three AXI router with independent read/write paths and DECERR target
module mmio_router
    import mmio_router_pkg::*;
#(
    parameter logic [30:0] UART_BASE = UART_BASE_DEF,
    parameter logic [30:0] BRAM_BASE = BRAM_BASE_DEF,
    parameter logic [30:0] SPI_BASE  = SPI_BASE_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         s_aw_valid,
    output logic         s_aw_ready,
    input  logic [3:0]   s_aw_id,
    input  logic [30:0]  s_aw_addr,
    input  logic [7:0]   s_aw_len,
    input  logic [2:0]   s_aw_size,
    input  logic [1:0]   s_aw_burst,
    input  logic         s_w_valid,
    output logic         s_w_ready,
    input  logic [63:0]  s_w_data,
    input  logic [7:0]   s_w_strb,
    input  logic         s_w_last,
    output logic         s_b_valid,
    input  logic         s_b_ready,
    output logic [3:0]   s_b_id,
    output logic [1:0]   s_b_resp,
    input  logic         s_ar_valid,
    output logic         s_ar_ready,
    input  logic [3:0]   s_ar_id,
    input  logic [30:0]  s_ar_addr,
    input  logic [7:0]   s_ar_len,
    input  logic [2:0]   s_ar_size,
    input  logic [1:0]   s_ar_burst,
    output logic         s_r_valid,
    input  logic         s_r_ready,
    output logic [3:0]   s_r_id,
    output logic [63:0]  s_r_data,
    output logic [1:0]   s_r_resp,
    output logic         s_r_last,
    output logic [2:0]   m_aw_valid,
    input  logic [2:0]   m_aw_ready,
    output logic [11:0]  m_aw_id,
    output logic [92:0]  m_aw_addr,
    output logic [23:0]  m_aw_len,
    output logic [8:0]   m_aw_size,
    output logic [5:0]   m_aw_burst,
    output logic [2:0]   m_w_valid,
    input  logic [2:0]   m_w_ready,
    output logic [191:0] m_w_data,
    output logic [23:0]  m_w_strb,
    output logic [2:0]   m_w_last,
    input  logic [2:0]   m_b_valid,
    output logic [2:0]   m_b_ready,
    input  logic [11:0]  m_b_id,
    input  logic [5:0]   m_b_resp,
    output logic [2:0]   m_ar_valid,
    input  logic [2:0]   m_ar_ready,
    output logic [11:0]  m_ar_id,
    output logic [92:0]  m_ar_addr,
    output logic [23:0]  m_ar_len,
    output logic [8:0]   m_ar_size,
    output logic [5:0]   m_ar_burst,
    input  logic [2:0]   m_r_valid,
    output logic [2:0]   m_r_ready,
    input  logic [11:0]  m_r_id,
    input  logic [191:0] m_r_data,
    input  logic [5:0]   m_r_resp,
    input  logic [2:0]   m_r_last
);

    wr_state_t   wr_state_q, wr_state_d;
    rd_state_t   rd_state_q, rd_state_d;
    logic        up_q;
    logic [3:0]  aw_id_q, ar_id_q;
    logic [30:0] aw_addr_q, ar_addr_q;
    logic [7:0]  aw_len_q, ar_len_q, rd_cnt_q, rd_cnt_d;
    logic [2:0]  aw_size_q, ar_size_q;
    logic [1:0]  aw_burst_q, ar_burst_q, wslot_q, rslot_q, aw_slot, ar_slot;
    logic        whit_q, rhit_q, aw_hit, ar_hit, aw_hs, ar_hs;

    mmio_addr_decode #(.UART_BASE(UART_BASE), .BRAM_BASE(BRAM_BASE), .SPI_BASE(SPI_BASE))
        u_aw_dec (.addr_i(s_aw_addr), .slot_o(aw_slot), .hit_o(aw_hit));
    mmio_addr_decode #(.UART_BASE(UART_BASE), .BRAM_BASE(BRAM_BASE), .SPI_BASE(SPI_BASE))
        u_ar_dec (.addr_i(s_ar_addr), .slot_o(ar_slot), .hit_o(ar_hit));

    assign aw_hs = s_aw_valid && s_aw_ready;
    assign ar_hs = s_ar_valid && s_ar_ready;

    assign m_aw_id    = {NSLOT{aw_id_q}};
    assign m_aw_addr  = {NSLOT{aw_addr_q}};
    assign m_aw_len   = {NSLOT{aw_len_q}};
    assign m_aw_size  = {NSLOT{aw_size_q}};
    assign m_aw_burst = {NSLOT{aw_burst_q}};
    assign m_w_data   = {NSLOT{s_w_data}};
    assign m_w_strb   = {NSLOT{s_w_strb}};
    assign m_w_last   = {NSLOT{s_w_last}};
    assign m_ar_id    = {NSLOT{ar_id_q}};
    assign m_ar_addr  = {NSLOT{ar_addr_q}};
    assign m_ar_len   = {NSLOT{ar_len_q}};
    assign m_ar_size  = {NSLOT{ar_size_q}};
    assign m_ar_burst = {NSLOT{ar_burst_q}};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
        end
    end

    // up_q holds the IDLE readies low until the first edge after reset release.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            up_q       <= 1'b0;
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            wslot_q    <= '0;
            whit_q     <= 1'b0;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            rslot_q    <= '0;
            rhit_q     <= 1'b0;
            rd_cnt_q   <= '0;
        end else begin
            up_q     <= 1'b1;
            rd_cnt_q <= rd_cnt_d;
            if (aw_hs) begin
                aw_id_q    <= s_aw_id;
                aw_addr_q  <= s_aw_addr;
                aw_len_q   <= s_aw_len;
                aw_size_q  <= s_aw_size;
                aw_burst_q <= s_aw_burst;
                wslot_q    <= aw_slot;
                whit_q     <= aw_hit;
            end
            if (ar_hs) begin
                ar_id_q    <= s_ar_id;
                ar_addr_q  <= s_ar_addr;
                ar_len_q   <= s_ar_len;
                ar_size_q  <= s_ar_size;
                ar_burst_q <= s_ar_burst;
                rslot_q    <= ar_slot;
                rhit_q     <= ar_hit;
            end
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            WR_IDLE: if (aw_hs) wr_state_d = aw_hit ? WR_ADDR : WR_DATA;
            WR_ADDR: if (m_aw_ready[wslot_q]) wr_state_d = WR_DATA;
            WR_DATA: if (s_w_valid && s_w_ready && s_w_last) wr_state_d = WR_RESP;
            WR_RESP: if (s_b_valid && s_b_ready) wr_state_d = WR_IDLE;
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        s_aw_ready = 1'b0;
        m_aw_valid = '0;
        s_w_ready  = 1'b0;
        m_w_valid  = '0;
        s_b_valid  = 1'b0;
        m_b_ready  = '0;
        s_b_id     = aw_id_q;
        s_b_resp   = RESP_DECERR;
        case (wr_state_q)
            WR_IDLE: s_aw_ready = up_q;
            WR_ADDR: m_aw_valid[wslot_q] = whit_q;
            WR_DATA: begin
                if (whit_q) begin
                    m_w_valid[wslot_q] = s_w_valid;
                    s_w_ready          = m_w_ready[wslot_q];
                end else begin
                    s_w_ready = 1'b1;
                end
            end
            WR_RESP: begin
                if (whit_q) begin
                    m_b_ready[wslot_q] = s_b_ready;
                    s_b_valid          = m_b_valid[wslot_q];
                    s_b_id             = m_b_id[{wslot_q, 2'b00} +: 4];
                    s_b_resp           = m_b_resp[{wslot_q, 1'b0} +: 2];
                end else begin
                    s_b_valid = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        case (rd_state_q)
            RD_IDLE: if (ar_hs) begin
                rd_state_d = ar_hit ? RD_ADDR : RD_DATA;
                rd_cnt_d   = s_ar_len;
            end
            RD_ADDR: if (m_ar_ready[rslot_q]) rd_state_d = RD_DATA;
            RD_DATA: if (s_r_valid && s_r_ready) begin
                rd_cnt_d = rd_cnt_q - 8'd1;
                if (s_r_last) rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // The DECERR target sources its own beats; last comes from the local countdown.
    always_comb begin
        s_ar_ready = 1'b0;
        m_ar_valid = '0;
        s_r_valid  = 1'b0;
        m_r_ready  = '0;
        s_r_id     = ar_id_q;
        s_r_data   = '0;
        s_r_resp   = RESP_DECERR;
        s_r_last   = 1'b0;
        case (rd_state_q)
            RD_IDLE: s_ar_ready = up_q;
            RD_ADDR: m_ar_valid[rslot_q] = rhit_q;
            RD_DATA: begin
                if (rhit_q) begin
                    m_r_ready[rslot_q] = s_r_ready;
                    s_r_valid          = m_r_valid[rslot_q];
                    s_r_id             = m_r_id[{rslot_q, 2'b00} +: 4];
                    s_r_data           = m_r_data[{rslot_q, 6'd0} +: 64];
                    s_r_resp           = m_r_resp[{rslot_q, 1'b0} +: 2];
                    s_r_last           = m_r_last[rslot_q];
                end else begin
                    s_r_valid = 1'b1;
                    s_r_last  = (rd_cnt_q == 8'd0);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mmio_router.sv
// tb/tb_mmio_router.sv - directed vector bench for mmio_router with inline slave responders
module tb_mmio_router;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         s_aw_valid = 0, s_aw_ready;
    logic [3:0]   s_aw_id = 0;
    logic [30:0]  s_aw_addr = 0;
    logic [7:0]   s_aw_len = 0;
    logic [2:0]   s_aw_size = 0;
    logic [1:0]   s_aw_burst = 0;
    logic         s_w_valid = 0, s_w_ready;
    logic [63:0]  s_w_data = 0;
    logic [7:0]   s_w_strb = 0;
    logic         s_w_last = 0;
    logic         s_b_valid, s_b_ready = 0;
    logic [3:0]   s_b_id;
    logic [1:0]   s_b_resp;
    logic         s_ar_valid = 0, s_ar_ready;
    logic [3:0]   s_ar_id = 0;
    logic [30:0]  s_ar_addr = 0;
    logic [7:0]   s_ar_len = 0;
    logic [2:0]   s_ar_size = 0;
    logic [1:0]   s_ar_burst = 0;
    logic         s_r_valid, s_r_ready = 0;
    logic [3:0]   s_r_id;
    logic [63:0]  s_r_data;
    logic [1:0]   s_r_resp;
    logic         s_r_last;
    logic [2:0]   m_aw_valid, m_aw_ready = 0;
    logic [11:0]  m_aw_id;
    logic [92:0]  m_aw_addr;
    logic [23:0]  m_aw_len;
    logic [8:0]   m_aw_size;
    logic [5:0]   m_aw_burst;
    logic [2:0]   m_w_valid, m_w_ready = 0;
    logic [191:0] m_w_data;
    logic [23:0]  m_w_strb;
    logic [2:0]   m_w_last;
    logic [2:0]   m_b_valid = 0, m_b_ready;
    logic [11:0]  m_b_id = 0;
    logic [5:0]   m_b_resp = 0;
    logic [2:0]   m_ar_valid, m_ar_ready = 0;
    logic [11:0]  m_ar_id;
    logic [92:0]  m_ar_addr;
    logic [23:0]  m_ar_len;
    logic [8:0]   m_ar_size;
    logic [5:0]   m_ar_burst;
    logic [2:0]   m_r_valid = 0, m_r_ready;
    logic [11:0]  m_r_id = 0;
    logic [191:0] m_r_data = 0;
    logic [5:0]   m_r_resp = 0;
    logic [2:0]   m_r_last = 0;

    int n_vec = 0;
    int n_err = 0;

    mmio_router dut (
        .clock(clock), .reset(reset),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_id(s_aw_id), .s_aw_addr(s_aw_addr),
        .s_aw_len(s_aw_len), .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
        .s_w_last(s_w_last),
        .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_resp(s_b_resp),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_id(s_ar_id), .s_ar_addr(s_ar_addr),
        .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id), .s_r_data(s_r_data),
        .s_r_resp(s_r_resp), .s_r_last(s_r_last),
        .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_id(m_aw_id), .m_aw_addr(m_aw_addr),
        .m_aw_len(m_aw_len), .m_aw_size(m_aw_size), .m_aw_burst(m_aw_burst),
        .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
        .m_w_last(m_w_last),
        .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_id(m_b_id), .m_b_resp(m_b_resp),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_id(m_ar_id), .m_ar_addr(m_ar_addr),
        .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_id(m_r_id), .m_r_data(m_r_data),
        .m_r_resp(m_r_resp), .m_r_last(m_r_last)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        wr;
        logic [30:0] addr;
        logic [7:0]  len;
        logic [3:0]  id;
        logic [7:0]  strb;
        logic        hit;
        logic [1:0]  slot;
        logic        bp;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(logic wr, logic [30:0] a, logic [7:0] l, logic [3:0] id,
                                logic [7:0] strb, logic hit, logic [1:0] slot, logic bp);
        vec_t v;
        v.wr = wr; v.addr = a; v.len = l; v.id = id;
        v.strb = strb; v.hit = hit; v.slot = slot; v.bp = bp;
        return v;
    endfunction

    function automatic logic coin(logic bp);
        return bp ? ($urandom_range(0, 1) == 1) : 1'b1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr_txn(input vec_t v);
        int guard;
        int b;
        logic done;
        logic [2:0] oh;
        logic [63:0] d;
        oh = v.hit ? (3'b001 << v.slot) : 3'b000;
        @(posedge clock); #1;
        s_aw_valid = 1; s_aw_id = v.id; s_aw_addr = v.addr; s_aw_len = v.len;
        s_aw_size = 3'd3; s_aw_burst = 2'b01;
        guard = 0;
        @(negedge clock);
        while (!s_aw_ready && guard < 50) begin @(negedge clock); guard++; end
        chk("aw_accept", 64'(s_aw_ready), 64'd1);
        @(posedge clock); #1;
        s_aw_valid = 0;
        @(negedge clock);
        chk("aw_route", 64'(m_aw_valid), 64'(oh));
        if (v.hit) begin
            chk("aw_addr", 64'(m_aw_addr[v.slot*31 +: 31]), 64'(v.addr));
            chk("aw_len", 64'(m_aw_len[v.slot*8 +: 8]), 64'(v.len));
            done = 0; guard = 0;
            while (!done && guard < 50) begin
                @(posedge clock); #1;
                m_aw_ready = coin(v.bp) ? oh : 3'b000;
                @(negedge clock);
                if ((m_aw_valid & ~oh) != 0) chk("aw_cross", 64'(m_aw_valid), 64'(oh));
                done = (m_aw_valid & m_aw_ready & oh) != 0;
                guard++;
            end
            chk("aw_slave_hs", 64'(done), 64'd1);
        end
        b = 0; guard = 0;
        while (b <= int'(v.len) && guard < 300) begin
            @(posedge clock); #1;
            m_aw_ready = 0;
            d = 64'hC0DE_0000_0000_0000 | (64'(v.id) << 8) | 64'(b);
            s_w_valid = coin(v.bp); s_w_data = d; s_w_strb = v.strb;
            s_w_last = (b == int'(v.len));
            m_w_ready = coin(v.bp) ? oh : 3'b000;
            @(negedge clock);
            if (s_w_valid && s_w_ready) begin
                chk("w_route", 64'(m_w_valid), 64'(oh));
                if (v.hit) begin
                    chk("w_data", m_w_data[v.slot*64 +: 64], d);
                    chk("w_strb", 64'(m_w_strb[v.slot*8 +: 8]), 64'(v.strb));
                end
                b++;
            end else if ((m_w_valid & ~oh) != 0) begin
                chk("w_cross", 64'(m_w_valid), 64'(oh));
            end
            guard++;
        end
        chk("w_beats", 64'(b), 64'(v.len) + 64'd1);
        done = 0; guard = 0;
        while (!done && guard < 100) begin
            @(posedge clock); #1;
            s_w_valid = 0; s_w_last = 0; m_w_ready = 0;
            if (v.hit) begin
                m_b_valid = oh;
                m_b_id = {3{~v.id}};
                m_b_id[v.slot*4 +: 4] = v.id;
                m_b_resp = 6'b111111;
                m_b_resp[v.slot*2 +: 2] = 2'b00;
            end
            s_b_ready = coin(v.bp);
            @(negedge clock);
            if (s_b_valid && s_b_ready) begin
                chk("b_id", 64'(s_b_id), 64'(v.id));
                chk("b_resp", 64'(s_b_resp), v.hit ? 64'd0 : 64'd3);
                chk("b_mready", 64'(m_b_ready), 64'(oh));
                done = 1;
            end
            guard++;
        end
        chk("b_done", 64'(done), 64'd1);
        @(posedge clock); #1;
        s_b_ready = 0; m_b_valid = 0;
    endtask

    task automatic rd_txn(input vec_t v);
        int guard;
        int b;
        logic done;
        logic [2:0] oh;
        logic [63:0] d;
        oh = v.hit ? (3'b001 << v.slot) : 3'b000;
        @(posedge clock); #1;
        s_ar_valid = 1; s_ar_id = v.id; s_ar_addr = v.addr; s_ar_len = v.len;
        s_ar_size = 3'd3; s_ar_burst = 2'b01;
        guard = 0;
        @(negedge clock);
        while (!s_ar_ready && guard < 50) begin @(negedge clock); guard++; end
        chk("ar_accept", 64'(s_ar_ready), 64'd1);
        @(posedge clock); #1;
        s_ar_valid = 0;
        @(negedge clock);
        chk("ar_route", 64'(m_ar_valid), 64'(oh));
        if (v.hit) begin
            chk("ar_addr", 64'(m_ar_addr[v.slot*31 +: 31]), 64'(v.addr));
            done = 0; guard = 0;
            while (!done && guard < 50) begin
                @(posedge clock); #1;
                m_ar_ready = coin(v.bp) ? oh : 3'b000;
                @(negedge clock);
                if ((m_ar_valid & ~oh) != 0) chk("ar_cross", 64'(m_ar_valid), 64'(oh));
                done = (m_ar_valid & m_ar_ready & oh) != 0;
                guard++;
            end
            chk("ar_slave_hs", 64'(done), 64'd1);
        end
        b = 0; guard = 0;
        while (b <= int'(v.len) && guard < 300) begin
            @(posedge clock); #1;
            m_ar_ready = 0;
            d = 64'hFEED_0000_0000_0000 | (64'(v.id) << 8) | 64'(b);
            if (v.hit) begin
                m_r_valid = coin(v.bp) ? oh : 3'b000;
                m_r_data = {3{~d}};
                m_r_data[v.slot*64 +: 64] = d;
                m_r_id = {3{~v.id}};
                m_r_id[v.slot*4 +: 4] = v.id;
                m_r_resp = 6'b111111;
                m_r_resp[v.slot*2 +: 2] = 2'b00;
                m_r_last = 3'b111;
                m_r_last[v.slot] = (b == int'(v.len));
            end
            s_r_ready = coin(v.bp);
            @(negedge clock);
            if (s_r_valid && s_r_ready) begin
                chk("r_data", s_r_data, v.hit ? d : 64'd0);
                chk("r_id", 64'(s_r_id), 64'(v.id));
                chk("r_resp", 64'(s_r_resp), v.hit ? 64'd0 : 64'd3);
                chk("r_last", 64'(s_r_last), 64'(b == int'(v.len)));
                chk("r_mready", 64'(m_r_ready), 64'(oh));
                b++;
            end
            guard++;
        end
        chk("r_beats", 64'(b), 64'(v.len) + 64'd1);
        @(posedge clock); #1;
        m_r_valid = 0; m_r_last = 0; s_r_ready = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(1, 31'h6000_0004, 8'd0, 4'h3, 8'h0F, 1, 2'd0, 0);
        vecs[1]  = mk(0, 31'h6001_FFF8, 8'd3, 4'h5, 8'h00, 1, 2'd1, 0);
        vecs[2]  = mk(0, 31'h6002_1000, 8'd0, 4'h7, 8'h00, 0, 2'd0, 0);
        vecs[3]  = mk(1, 31'h7000_0000, 8'd2, 4'h9, 8'hFF, 0, 2'd0, 0);
        vecs[4]  = mk(0, 31'h6000_1FFF, 8'd0, 4'h1, 8'h00, 1, 2'd0, 0);
        vecs[5]  = mk(1, 31'h6000_2000, 8'd0, 4'h2, 8'hFF, 0, 2'd0, 0);
        vecs[6]  = mk(1, 31'h6002_0FFF, 8'd1, 4'hC, 8'hF0, 1, 2'd2, 0);
        vecs[7]  = mk(0, 31'h6001_0000, 8'd1, 4'hE, 8'h00, 1, 2'd1, 0);
        vecs[8]  = mk(0, 31'h6000_FFFF, 8'd1, 4'h4, 8'h00, 0, 2'd0, 0);
        vecs[9]  = mk(1, 31'h5FFF_FFFF, 8'd0, 4'h6, 8'h01, 0, 2'd0, 0);
        vecs[10] = mk(0, 31'h6001_FFF8, 8'd3, 4'hB, 8'h00, 1, 2'd1, 1);
        vecs[11] = mk(1, 31'h6001_8000, 8'd3, 4'hD, 8'h3C, 1, 2'd1, 1);

        repeat (2) @(negedge clock);
        chk("rst_aw_ready", 64'(s_aw_ready), 64'd0);
        chk("rst_ar_ready", 64'(s_ar_ready), 64'd0);
        chk("rst_valids", 64'({s_b_valid, s_r_valid, m_aw_valid, m_ar_valid}), 64'd0);
        reset = 0;
        #1;
        chk("rel_aw_ready_pre_edge", 64'(s_aw_ready), 64'd0);
        @(negedge clock);
        chk("rel_aw_ready", 64'(s_aw_ready), 64'd1);
        chk("rel_ar_ready", 64'(s_ar_ready), 64'd1);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) wr_txn(vecs[i]);
            else rd_txn(vecs[i]);
        end

        // Overlapping write to SPI and read from UART under backpressure.
        fork
            wr_txn(mk(1, 31'h6002_0010, 8'd3, 4'hA, 8'hFF, 1, 2'd2, 1));
            rd_txn(mk(0, 31'h6000_0100, 8'd2, 4'h6, 8'h00, 1, 2'd0, 1));
        join

        // Reset while beat 2 of a 4-beat BRAM read is on the bus.
        @(posedge clock); #1;
        s_ar_valid = 1; s_ar_id = 4'h2; s_ar_addr = 31'h6001_0040; s_ar_len = 8'd3;
        @(posedge clock); #1;
        s_ar_valid = 0; m_ar_ready = 3'b010;
        @(negedge clock);
        chk("mb_ar_route", 64'(m_ar_valid), 64'd2);
        @(posedge clock); #1;
        m_ar_ready = 0; m_r_valid = 3'b010; m_r_last = 3'b000; s_r_ready = 1;
        m_r_data = '0; m_r_data[127:64] = 64'h1111; m_r_id = 12'h020;
        @(negedge clock);
        chk("mb_beat1", 64'(s_r_valid), 64'd1);
        @(posedge clock); #1;
        m_r_data[127:64] = 64'h2222;
        @(negedge clock);
        chk("mb_beat2_data", s_r_data, 64'h2222);
        reset = 1;
        #1;
        chk("mb_rst_r_valid", 64'(s_r_valid), 64'd0);
        chk("mb_rst_m_r_ready", 64'(m_r_ready), 64'd0);
        chk("mb_rst_ar_ready", 64'(s_ar_ready), 64'd0);
        m_r_valid = 0; s_r_ready = 0; m_r_data = '0; m_r_id = '0;
        @(negedge clock);
        reset = 0;
        @(negedge clock);
        chk("mb_rel_ar_ready", 64'(s_ar_ready), 64'd1);
        rd_txn(mk(0, 31'h6001_0080, 8'd3, 4'h8, 8'h00, 1, 2'd1, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mmio_router.md
MMIO_ROUTER -- requirements
Module: mmio_router

Interface
REQ-001 SHALL have parameter UART_BASE, default 31'h6000_0000, UART window base (8 KiB window).
REQ-002 SHALL have parameter BRAM_BASE, default 31'h6001_0000, BRAM window base (64 KiB window).
REQ-003 SHALL have parameter SPI_BASE, default 31'h6002_0000, SPI window base (4 KiB window).
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with these ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- s_aw_{valid,ready,id,addr,len,size,burst}  in/out/in/in/in/in/in  1/1/4/31/8/3/2  upstream write address.
- s_w_{valid,ready,data,strb,last}  in/out/in/in/in  1/1/64/8/1  upstream write data.
- s_b_{valid,ready,id,resp}  out/in/out/out  1/1/4/2  upstream write response.
- s_ar_{valid,ready,id,addr,len,size,burst}  in/out/in/in/in/in/in  1/1/4/31/8/3/2  upstream read address.
- s_r_{valid,ready,id,data,resp,last}  out/in/out/out/out/out  1/1/4/64/2/1  upstream read data.
- m_* equivalents of every s_* signal, directions reversed, each field 3x wide and flattened; slot k is bits [k*W+W-1:k*W]; slot 0 UART, 1 BRAM, 2 SPI.

Function
REQ-005 SHALL decode each address against the three windows; a hit selects that slot; a miss selects the internal DECERR target.
REQ-006 SHALL run independent write and read FSMs, each with at most one outstanding transaction; reads and writes to the same slot may overlap.
REQ-007 Write FSM states SHALL be WR_IDLE, WR_ADDR, WR_DATA, WR_RESP.
- WR_IDLE: s_aw_ready=1; on AW handshake, register id/addr/len/size/burst and the decoded slot. Go to WR_ADDR on a hit, WR_DATA on a miss.
- WR_ADDR: m_aw_valid[slot]=1 with the registered fields; on handshake go to WR_DATA.
- WR_DATA: W is routed combinationally (s_w_ready = m_w_ready[slot]; m_w_valid[slot] = s_w_valid). On a miss, s_w_ready=1 and beats are discarded. The beat with last=1 moves the FSM to WR_RESP.
- WR_RESP: B is routed combinationally from the slot. On a miss, s_b_valid=1, s_b_resp=2'b11, s_b_id = registered id. The B handshake returns the FSM to WR_IDLE.
REQ-008 Read FSM states SHALL be RD_IDLE, RD_ADDR, RD_DATA, with the same address rules as REQ-007.
- RD_DATA: R is routed from the slot; the beat with last=1 handshaked returns the FSM to RD_IDLE.
- On a miss: emit len+1 beats with data=0, resp=2'b11 and the registered id; last=1 only on the final beat.
- The beat counter SHALL be 8 bits, decrement per handshake, and assert last at 0.
REQ-009 Latency: an upstream AW/AR handshake in cycle N SHALL give m_*_valid in cycle N+1. W, B and R forwarding SHALL add no cycles.
REQ-010 s_aw_ready and s_ar_ready SHALL be 0 outside their IDLE states.
REQ-011 Non-selected slots SHALL see valid=0 and ready=0. Address and payload fields SHALL be forwarded unmodified to all slots.
REQ-012 A W beat arriving before the AW handshake SHALL be held off (s_w_ready=0 in WR_IDLE and WR_ADDR).
REQ-013 Window boundaries are exact: the last byte of a window hits; last byte + 1 misses. Bursts crossing a window edge are decoded by start address only.

Reset
REQ-014 Reset SHALL force both FSMs to IDLE, all valid and ready outputs to 0, registered fields and beat counter to 0, at any point including mid-burst.
REQ-015 s_aw_ready and s_ar_ready SHALL assert in the first clock edge after reset deasserts.

Structure
REQ-016 A shared package SHALL hold:
- window base/size constants;
- slot index constants;
- the FSM state enums;
- the response codes OKAY=2'b00 and DECERR=2'b11.
REQ-017 One sub-module, mmio_addr_decode (combinational: addr -> slot, hit), SHALL be instantiated twice, once for AW and once for AR.

Verification
REQ-018 Write 0x6000_0004, len=0, strb=8'h0F -> m_aw_valid[0] one cycle later; one W beat forwarded on slot 0; B OKAY returned with the upstream id.
REQ-019 Read 0x6001_FFF8, len=3 -> all four beats from slot 1 forwarded, last on beat 4. Read 0x6002_1000 -> DECERR, data 0, single beat with last=1.
REQ-020 Write 0x7000_0000, len=2 -> three W beats absorbed, no m_*_valid asserted, B resp=2'b11.
REQ-021 Concurrent write to slot 2 and read from slot 0 with random backpressure on all readies -> both complete with correct ids and no cross-slot valids.
REQ-022 Reset asserted during beat 2 of a 4-beat read -> s_r_valid=0 immediately; s_ar_ready=1 after deassertion; a new read completes normally.
